// File: rtl/xtea_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xtea_pkg
// Description : Shared types and widths for the XTEA block sequencer.
//               Holds the sequencer state encoding and the block/key widths.
// Revision    : 1.0 - initial release
// ============================================================================
package xtea_pkg;

    localparam int XTEA_BLOCK_W = 64;
    localparam int XTEA_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage : xtea_pkg
`default_nettype wire

// File: rtl/xtea_block_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : xtea_watchdog
// Description : Cycle counter that flags a cipher core that never completes.
//               Counts while enabled, saturates at TIMEOUT-1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   system clock
//   reset    in   asynchronous, active-high
//   clear    in   synchronous clear of the count (wins over enable)
//   enable   in   advance the count by one
//   expired  out  count has reached TIMEOUT-1
// ============================================================================
module xtea_watchdog #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : xtea_watchdog
`default_nettype wire

// File: rtl/xtea_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xtea_block_sequencer
// Description : Runs one 64-bit block at a time through an external XTEA
//               encipher or decipher core, with ECB or CBC chaining and a
//               watchdog on core completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset                     clock; asynchronous active-high reset
//   in_valid/in_ready                block input handshake
//   in_data1/2, in_decrypt,
//   in_chain_start                   block words, direction, IV reload
//   cfg_cbc, cfg_key, cfg_iv         mode, key and IV (sampled on accept)
//   out_valid/out_ready              result handshake
//   out_data1/2, out_error           result words; error = watchdog expired
//   core_key                         key held for both cores
//   enc_start, enc_data1/2           encipher core start pulse and inputs
//   enc_done, enc_res1/2             encipher core completion and result
//   dec_start, dec_data1/2           decipher core start pulse and inputs
//   dec_done, dec_res1/2             decipher core completion and result
// ============================================================================
module xtea_block_sequencer
    import xtea_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data1,
    input  logic [31:0]             in_data2,
    input  logic                    in_decrypt,
    input  logic                    in_chain_start,
    input  logic                    cfg_cbc,
    input  logic [XTEA_KEY_W-1:0]   cfg_key,
    input  logic [XTEA_BLOCK_W-1:0] cfg_iv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data1,
    output logic [31:0]             out_data2,
    output logic                    out_error,
    output logic [XTEA_KEY_W-1:0]   core_key,
    output logic                    enc_start,
    output logic [31:0]             enc_data1,
    output logic [31:0]             enc_data2,
    input  logic                    enc_done,
    input  logic [31:0]             enc_res1,
    input  logic [31:0]             enc_res2,
    output logic                    dec_start,
    output logic [31:0]             dec_data1,
    output logic [31:0]             dec_data2,
    input  logic                    dec_done,
    input  logic [31:0]             dec_res1,
    input  logic [31:0]             dec_res2
);

    state_t                  state_q, state_d;
    logic [XTEA_KEY_W-1:0]   key_q, key_d;
    logic                    decrypt_q, decrypt_d;
    logic                    cbc_q, cbc_d;
    logic [XTEA_BLOCK_W-1:0] chain_q, chain_d;
    logic [XTEA_BLOCK_W-1:0] core_in_q, core_in_d;
    logic [XTEA_BLOCK_W-1:0] saved_ct_q, saved_ct_d;
    logic [XTEA_BLOCK_W-1:0] out_q, out_d;
    logic                    out_err_q, out_err_d;

    logic [XTEA_BLOCK_W-1:0] in_block;
    logic [XTEA_BLOCK_W-1:0] chain_sel;
    logic [XTEA_BLOCK_W-1:0] sel_res;
    logic                    sel_done;
    logic                    wd_clear;
    logic                    wd_enable;
    logic                    wd_expired;

    assign in_block  = {in_data1, in_data2};
    // A chain restart makes the fresh IV visible to this same block's XOR.
    assign chain_sel = in_chain_start ? cfg_iv : chain_q;
    assign sel_done  = decrypt_q ? dec_done : enc_done;
    assign sel_res   = decrypt_q ? {dec_res1, dec_res2} : {enc_res1, enc_res2};

    xtea_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        decrypt_d  = decrypt_q;
        cbc_d      = cbc_q;
        chain_d    = chain_q;
        core_in_d  = core_in_q;
        saved_ct_d = saved_ct_q;
        out_d      = out_q;
        out_err_d  = out_err_q;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d      = cfg_key;
                    decrypt_d  = in_decrypt;
                    cbc_d      = cfg_cbc;
                    chain_d    = chain_sel;
                    saved_ct_d = in_block;
                    // Only the encipher direction whitens its input with the chain.
                    core_in_d  = (!in_decrypt && cfg_cbc) ? (in_block ^ chain_sel) : in_block;
                    state_d    = START;
                end
            end
            START: begin
                // Counter is zero on the first RUN cycle.
                wd_clear = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                wd_enable = 1'b1;
                // Completion on the last allowed cycle beats the watchdog.
                if (sel_done) begin
                    out_err_d = 1'b0;
                    state_d   = OUT;
                    if (decrypt_q) begin
                        out_d = cbc_q ? (sel_res ^ chain_q) : sel_res;
                        if (cbc_q) begin
                            chain_d = saved_ct_q;
                        end
                    end else begin
                        out_d = sel_res;
                        if (cbc_q) begin
                            chain_d = sel_res;
                        end
                    end
                end else if (wd_expired) begin
                    out_d     = '0;
                    out_err_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            decrypt_q  <= 1'b0;
            cbc_q      <= 1'b0;
            chain_q    <= '0;
            core_in_q  <= '0;
            saved_ct_q <= '0;
            out_q      <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            decrypt_q  <= decrypt_d;
            cbc_q      <= cbc_d;
            chain_q    <= chain_d;
            core_in_q  <= core_in_d;
            saved_ct_q <= saved_ct_d;
            out_q      <= out_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data1 = out_q[63:32];
    assign out_data2 = out_q[31:0];
    assign out_error = out_err_q;
    assign core_key  = key_q;
    assign enc_start = (state_q == START) && !decrypt_q;
    assign dec_start = (state_q == START) &&  decrypt_q;
    assign enc_data1 = core_in_q[63:32];
    assign enc_data2 = core_in_q[31:0];
    assign dec_data1 = core_in_q[63:32];
    assign dec_data2 = core_in_q[31:0];

endmodule : xtea_block_sequencer
`default_nettype wire

// File: tb/tb_xtea_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xtea_block_sequencer
// Description : Self-checking bench for xtea_block_sequencer. Emulates both
//               cipher cores with a behavioural XTEA and a chosen latency, and
//               predicts every output from a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xtea_block_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam logic [127:0] K1 = 128'h11111111_22222222_33333333_44444444;

    logic         clock;
    logic         reset;
    logic         in_valid, in_ready;
    logic [31:0]  in_data1, in_data2;
    logic         in_decrypt, in_chain_start, cfg_cbc;
    logic [127:0] cfg_key;
    logic [63:0]  cfg_iv;
    logic         out_valid, out_ready;
    logic [31:0]  out_data1, out_data2;
    logic         out_error;
    logic [127:0] core_key;
    logic         enc_start, enc_done, dec_start, dec_done;
    logic [31:0]  enc_data1, enc_data2, enc_res1, enc_res2;
    logic [31:0]  dec_data1, dec_data2, dec_res1, dec_res2;

    int n_cmp = 0;
    int n_bad = 0;

    xtea_block_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data1(in_data1), .in_data2(in_data2),
        .in_decrypt(in_decrypt), .in_chain_start(in_chain_start),
        .cfg_cbc(cfg_cbc), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2), .out_error(out_error),
        .core_key(core_key),
        .enc_start(enc_start), .enc_data1(enc_data1), .enc_data2(enc_data2),
        .enc_done(enc_done), .enc_res1(enc_res1), .enc_res2(enc_res2),
        .dec_start(dec_start), .dec_data1(dec_data1), .dec_data2(dec_data2),
        .dec_done(dec_done), .dec_res1(dec_res1), .dec_res2(dec_res2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference XTEA (32 cycles, k0 = key[127:96]) ----------
    function automatic logic [63:0] xtea_enc(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        logic [31:0] kw [4];
        kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
        v0 = v[63:32]; v1 = v[31:0]; sum = 32'd0;
        for (int i = 0; i < 32; i++) begin
            v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
            sum = sum + 32'h9E3779B9;
            v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] xtea_dec(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        logic [31:0] kw [4];
        kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
        v0 = v[63:32]; v1 = v[31:0]; sum = 32'hC6EF3720;
        for (int i = 0; i < 32; i++) begin
            v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
            sum = sum - 32'h9E3779B9;
            v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
        end
        return {v0, v1};
    endfunction

    // ---------------- core emulation --------------------------------------
    // Latency L: done rises L cycles after the start edge (L=0: at that edge).
    int cur_lat = 0;
    int enc_cnt, dec_cnt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            enc_done <= 1'b0; enc_cnt <= 0; enc_res1 <= 32'd0; enc_res2 <= 32'd0;
        end else if (enc_start) begin
            if (cur_lat == 0) begin
                enc_done <= 1'b1;
                {enc_res1, enc_res2} <= xtea_enc({enc_data1, enc_data2}, core_key);
            end else begin
                enc_done <= 1'b0; enc_cnt <= cur_lat;
                enc_res1 <= $urandom; enc_res2 <= $urandom;
            end
        end else if (enc_cnt > 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) begin
                enc_done <= 1'b1;
                {enc_res1, enc_res2} <= xtea_enc({enc_data1, enc_data2}, core_key);
            end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_done <= 1'b0; dec_cnt <= 0; dec_res1 <= 32'd0; dec_res2 <= 32'd0;
        end else if (dec_start) begin
            if (cur_lat == 0) begin
                dec_done <= 1'b1;
                {dec_res1, dec_res2} <= xtea_dec({dec_data1, dec_data2}, core_key);
            end else begin
                dec_done <= 1'b0; dec_cnt <= cur_lat;
                dec_res1 <= $urandom; dec_res2 <= $urandom;
            end
        end else if (dec_cnt > 0) begin
            dec_cnt <= dec_cnt - 1;
            if (dec_cnt == 1) begin
                dec_done <= 1'b1;
                {dec_res1, dec_res2} <= xtea_dec({dec_data1, dec_data2}, core_key);
            end
        end
    end

    // ---------------- result-side backpressure ------------------------------
    int bp_mode = 0;   // 0: always ready, 1: random, 2: held low
    always @(posedge clock) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- transaction model + compare ---------------------------
    bit           in_flight = 0;
    int           cyc = 0;
    int           start_cyc = -1;
    int           ov_due = 0;
    int           run_cycles;
    logic         exp_dir = 1'b0;
    logic [63:0]  exp_out = '0;
    logic         exp_err = 1'b0;
    logic [127:0] exp_key = '0;
    logic [63:0]  m_chain = '0;
    logic [63:0]  m_chain_n, m_pin, m_tmp;
    logic [63:0]  last_out = '0;
    logic         last_err = 1'b0;
    int           n_done = 0;
    bit           exp_ov;

    always @(negedge clock) begin
        if (reset) begin
            in_flight = 0;
            m_chain   = '0;
        end else begin
            cyc++;
            chk("in_ready", in_ready, !in_flight);
            chk("enc_start", enc_start, in_flight && (cyc == start_cyc) && !exp_dir);
            chk("dec_start", dec_start, in_flight && (cyc == start_cyc) && exp_dir);
            if (in_flight && cyc >= start_cyc) chk("core_key", core_key, exp_key);
            exp_ov = in_flight && (cyc >= ov_due);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_data", {out_data1, out_data2}, exp_out);
                chk("out_error", out_error, exp_err);
                if (out_ready) begin
                    last_out  = {out_data1, out_data2};
                    last_err  = out_error;
                    in_flight = 0;
                    n_done++;
                end
            end
            if (in_valid && in_ready) begin
                m_pin     = {in_data1, in_data2};
                m_chain_n = in_chain_start ? cfg_iv : m_chain;
                exp_dir   = in_decrypt;
                exp_key   = cfg_key;
                if (cur_lat > TIMEOUT - 1) begin
                    exp_out = '0; exp_err = 1'b1; m_chain = m_chain_n;
                    run_cycles = TIMEOUT;
                end else begin
                    exp_err = 1'b0;
                    run_cycles = cur_lat + 1;
                    if (!in_decrypt) begin
                        m_tmp   = xtea_enc(cfg_cbc ? (m_pin ^ m_chain_n) : m_pin, cfg_key);
                        exp_out = m_tmp;
                        m_chain = cfg_cbc ? m_tmp : m_chain_n;
                    end else begin
                        m_tmp   = xtea_dec(m_pin, cfg_key);
                        exp_out = cfg_cbc ? (m_tmp ^ m_chain_n) : m_tmp;
                        m_chain = cfg_cbc ? m_pin : m_chain_n;
                    end
                end
                in_flight = 1;
                start_cyc = cyc + 1;
                ov_due    = cyc + run_cycles + 2;
            end
        end
    end

    // ---------------- driver ------------------------------------------------
    task automatic scramble_inputs();
        in_data1 = $urandom; in_data2 = $urandom;
        in_decrypt = 1'($urandom_range(0, 1)); in_chain_start = 1'($urandom_range(0, 1));
        cfg_cbc = 1'($urandom_range(0, 1));
        cfg_key = {$urandom, $urandom, $urandom, $urandom};
        cfg_iv  = {$urandom, $urandom};
    endtask

    task automatic send(input logic [31:0] d1, input logic [31:0] d2, input logic dec,
                        input logic cs, input logic cbc, input logic [127:0] key,
                        input logic [63:0] iv, input int lat);
        bit ok;
        @(posedge clock); #1;
        in_data1 = d1; in_data2 = d2; in_decrypt = dec; in_chain_start = cs;
        cfg_cbc = cbc; cfg_key = key; cfg_iv = iv; cur_lat = lat; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 400 cycles");
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (n_done >= target) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: completed %0d expected %0d", n_done, target);
        end
    endtask

    logic [63:0]  c1, c2, pr;
    logic [127:0] kr;
    int           lr;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data1 = '0; in_data2 = '0;
        in_decrypt = 1'b0; in_chain_start = 1'b0; cfg_cbc = 1'b0;
        cfg_key = '0; cfg_iv = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // reset state
        @(negedge clock);
        chk("rst_out_data", {out_data1, out_data2}, 64'd0);
        chk("rst_out_error", out_error, 1'b0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_enc_data", {enc_data1, enc_data2}, 64'd0);

        // reference model pinned to known vectors
        chk("model_enc_k0", xtea_enc(64'd0, 128'd0), 64'hdee9d4d8_f7131ed9);
        chk("model_enc_k1", xtea_enc(64'd0, K1), 64'hf07ac290_23c92672);
        chk("model_dec_k1", xtea_dec(64'hf07ac290_23c92672, K1), 64'd0);

        // ECB encrypt, zero key
        send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 128'd0, 64'd0, 3);
        wait_done(1);
        chk("ecb_k0", last_out, 64'hdee9d4d8_f7131ed9);
        chk("ecb_k0_err", last_err, 1'b0);

        // ECB encrypt then decrypt with K1
        send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, K1, 64'd0, 5);
        wait_done(2);
        chk("ecb_k1_enc", last_out, 64'hf07ac290_23c92672);
        send(32'hf07ac290, 32'h23c92672, 1'b1, 1'b0, 1'b0, K1, 64'd0, 0);
        wait_done(3);
        chk("ecb_k1_dec", last_out, 64'd0);

        // CBC encrypt two blocks, then decrypt them
        send(32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 128'd0, 64'd0, 2);
        wait_done(4);
        c1 = last_out;
        chk("cbc_c1", c1, 64'hdee9d4d8_f7131ed9);
        send(32'h12345678, 32'h9abcdeff, 1'b0, 1'b0, 1'b1, 128'd0, 64'hffff_ffff_ffff_ffff, 7);
        wait_done(5);
        c2 = last_out;
        chk("cbc_c2", c2, xtea_enc(64'h12345678_9abcdeff ^ c1, 128'd0));
        send(c1[63:32], c1[31:0], 1'b1, 1'b1, 1'b1, 128'd0, 64'd0, 4);
        wait_done(6);
        chk("cbc_p1", last_out, 64'd0);
        // latency 15 -> done on the final cycle the watchdog allows
        send(c2[63:32], c2[31:0], 1'b1, 1'b0, 1'b1, 128'd0, 64'd0, 15);
        wait_done(7);
        chk("cbc_p2", last_out, 64'h12345678_9abcdeff);

        // backpressure: result held for many cycles
        bp_mode = 2;
        send(32'haaaa5555, 32'h0f0f1234, 1'b0, 1'b0, 1'b0, K1, 64'd0, 1);
        repeat (14) @(negedge clock);
        chk("bp_held_valid", out_valid, 1'b1);
        bp_mode = 0;
        wait_done(8);
        chk("bp_data", last_out, xtea_enc(64'haaaa5555_0f0f1234, K1));

        // watchdog: core never finishes, then one cycle too late
        send(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, K1, 64'd0, 99);
        wait_done(9);
        chk("wd_err", last_err, 1'b1);
        chk("wd_data", last_out, 64'd0);
        send(32'd1, 32'd2, 1'b1, 1'b0, 1'b1, K1, 64'd0, 16);
        wait_done(10);
        chk("wd_err_boundary", last_err, 1'b1);
        // chain is still C2 from the CBC decrypt sequence
        send(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, K1, 64'd0, 3);
        wait_done(11);
        chk("wd_recover", last_out, xtea_enc(64'h00000001_00000002 ^ c2, K1));
        chk("wd_recover_err", last_err, 1'b0);

        // asynchronous reset in the middle of RUN
        send(32'd5, 32'd6, 1'b0, 1'b0, 1'b1, K1, 64'd0, 10);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_starts", {enc_start, dec_start}, 2'b00);
        chk("rst_mid_key", core_key, 128'd0);
        @(posedge clock); #1 reset = 1'b0;
        send(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 128'd0, 64'hdead_beef_dead_beef, 2);
        wait_done(12);
        chk("rst_chain_zero", last_out, 64'hdee9d4d8_f7131ed9);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            bp_mode = int'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       lr = 15;
                1:       lr = 16;
                2:       lr = 40;
                default: lr = int'($urandom_range(0, 12));
            endcase
            kr = ($urandom_range(0, 1) == 0) ? K1 : {$urandom, $urandom, $urandom, $urandom};
            pr = {$urandom, $urandom};
            send(pr[63:32], pr[31:0], 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 kr, {$urandom, $urandom}, lr);
        end
        bp_mode = 0;
        wait_done(72);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_xtea_block_sequencer
`default_nettype wire
